// File: rtl/stack_port.sv
// stack_port
// Sequences one Forth stack push or pop per command against data memory.
// It reads the current stack pointer exported by the register file and runs
// a request/acknowledge memory transaction. It then writes the updated
// pointer back through the register-file write port.
//
// Ports:
//   c_CLOCK, c_RESET_N        clock, asynchronous active-low reset
//   i_REQ, i_OP, i_SEL        command request, 0=push/1=pop, 0=PSP/1=RSP
//   i_WDATA                   push data
//   i_PSP, i_RSP              current stack pointers from the register file
//   o_BUSY, o_DONE, o_ERR     status: busy, completion pulse, fault pulse
//   o_RDATA                   last popped value
//   o_MREQ, o_MWE, o_MADDR,
//   o_MWDATA, i_MRDATA, i_MACK  memory request/acknowledge port
//   o_WADDR, o_DATA, o_WRITE  register-file pointer write port
module stack_port #(
   parameter logic [15:0] PS_BASE  = 16'd48,
   parameter logic [15:0] PS_LIMIT = 16'd56,
   parameter logic [15:0] RS_BASE  = 16'd56,
   parameter logic [15:0] RS_LIMIT = 16'd64
) (
   input  logic        c_CLOCK,
   input  logic        c_RESET_N,
   input  logic        i_REQ,
   input  logic        i_OP,
   input  logic        i_SEL,
   input  logic [15:0] i_WDATA,
   input  logic [15:0] i_PSP,
   input  logic [15:0] i_RSP,
   output logic        o_BUSY,
   output logic        o_DONE,
   output logic        o_ERR,
   output logic [15:0] o_RDATA,
   output logic        o_MREQ,
   output logic        o_MWE,
   output logic [15:0] o_MADDR,
   output logic [15:0] o_MWDATA,
   input  logic [15:0] i_MRDATA,
   input  logic        i_MACK,
   output logic [3:0]  o_WADDR,
   output logic [15:0] o_DATA,
   output logic        o_WRITE
);

   typedef enum logic [1:0] {IDLE, MEM, WB, ERR} state_t;

   state_t      state, state_next;

   logic        op, op_next;
   logic        sel, sel_next;
   logic [15:0] wdata, wdata_next;
   logic [15:0] sp, sp_next;

   logic [15:0] sp_in, base, limit;

   logic        busy_next, done_next, err_next;
   logic        mreq_next, mwe_next, write_next;
   logic [15:0] maddr_next, mwdata_next, data_next, rdata_next;
   logic [3:0]  waddr_next;

   // Next-state and next-output logic. Every output is computed here from the
   // state being entered and registered below. This keeps all outputs free
   // of combinational paths from the inputs while staying aligned with the
   // state.
   always_comb begin
      state_next = state;
      op_next    = op;
      sel_next   = sel;
      wdata_next = wdata;
      sp_next    = sp;
      sp_in      = i_SEL ? i_RSP : i_PSP;
      base       = i_SEL ? RS_BASE : PS_BASE;
      limit      = i_SEL ? RS_LIMIT : PS_LIMIT;

      case (state)
         IDLE: begin
            if (i_REQ) begin
               op_next    = i_OP;
               sel_next   = i_SEL;
               wdata_next = i_WDATA;
               sp_next    = sp_in;
               if ((!i_OP && sp_in >= limit) || (i_OP && sp_in <= base))
                  state_next = ERR;
               else
                  state_next = MEM;
            end
         end
         MEM: begin
            if (i_MACK)
               state_next = WB;
         end
         WB:      state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase

      busy_next   = (state_next != IDLE);
      mreq_next   = (state_next == MEM);
      mwe_next    = (state_next == MEM) && !op_next;
      maddr_next  = (state_next == MEM) ? (op_next ? sp_next - 16'd1 : sp_next) : 16'd0;
      mwdata_next = ((state_next == MEM) && !op_next) ? wdata_next : 16'd0;
      write_next  = (state_next == WB);
      waddr_next  = (state_next == WB) ? (sel_next ? 4'd2 : 4'd1) : 4'd0;
      data_next   = (state_next == WB) ? (op_next ? sp_next - 16'd1 : sp_next + 16'd1) : 16'd0;
      done_next   = (state_next == WB) || (state_next == ERR);
      err_next    = (state_next == ERR);
      rdata_next  = (state == MEM && i_MACK && op) ? i_MRDATA : o_RDATA;
   end

   // State, latched command and registered outputs. Reset drops any
   // in-flight memory request at once, so no pointer write follows it.
   always_ff @(posedge c_CLOCK or negedge c_RESET_N) begin
      if (!c_RESET_N) begin
         state    <= IDLE;
         op       <= 1'b0;
         sel      <= 1'b0;
         wdata    <= 16'd0;
         sp       <= 16'd0;
         o_BUSY   <= 1'b0;
         o_DONE   <= 1'b0;
         o_ERR    <= 1'b0;
         o_RDATA  <= 16'd0;
         o_MREQ   <= 1'b0;
         o_MWE    <= 1'b0;
         o_MADDR  <= 16'd0;
         o_MWDATA <= 16'd0;
         o_WADDR  <= 4'd0;
         o_DATA   <= 16'd0;
         o_WRITE  <= 1'b0;
      end else begin
         state    <= state_next;
         op       <= op_next;
         sel      <= sel_next;
         wdata    <= wdata_next;
         sp       <= sp_next;
         o_BUSY   <= busy_next;
         o_DONE   <= done_next;
         o_ERR    <= err_next;
         o_RDATA  <= rdata_next;
         o_MREQ   <= mreq_next;
         o_MWE    <= mwe_next;
         o_MADDR  <= maddr_next;
         o_MWDATA <= mwdata_next;
         o_WADDR  <= waddr_next;
         o_DATA   <= data_next;
         o_WRITE  <= write_next;
      end
   end

endmodule

// File: tb/tb_stack_port.sv
// tb_stack_port
// Self-checking bench for stack_port. The bench plays the register file and
// the data memory and keeps a cycle-level model of the expected outputs. It
// also runs directed command sequences with hand-computed expectations.
module tb_stack_port;

   localparam logic [15:0] PS_BASE  = 16'd48;
   localparam logic [15:0] PS_LIMIT = 16'd56;
   localparam logic [15:0] RS_BASE  = 16'd56;
   localparam logic [15:0] RS_LIMIT = 16'd64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_REQ, i_OP, i_SEL;
   logic [15:0] i_WDATA, i_PSP, i_RSP, i_MRDATA;
   logic        i_MACK;
   logic        o_BUSY, o_DONE, o_ERR, o_MREQ, o_MWE, o_WRITE;
   logic [15:0] o_RDATA, o_MADDR, o_MWDATA, o_DATA;
   logic [3:0]  o_WADDR;

   int total = 0;
   int bad   = 0;

   logic [15:0] psp = PS_BASE;
   logic [15:0] rsp = RS_BASE;
   int          ack_delay = 0;
   logic        ov_en = 1'b0;
   logic        ov_sel = 1'b0;
   logic [15:0] ov_val = 16'd0;

   assign i_PSP = psp;
   assign i_RSP = rsp;

   always #5 clk = ~clk;

   stack_port #(
      .PS_BASE (PS_BASE),
      .PS_LIMIT(PS_LIMIT),
      .RS_BASE (RS_BASE),
      .RS_LIMIT(RS_LIMIT)
   ) dut (
      .c_CLOCK  (clk),
      .c_RESET_N(rst_n),
      .i_REQ    (i_REQ),
      .i_OP     (i_OP),
      .i_SEL    (i_SEL),
      .i_WDATA  (i_WDATA),
      .i_PSP    (i_PSP),
      .i_RSP    (i_RSP),
      .o_BUSY   (o_BUSY),
      .o_DONE   (o_DONE),
      .o_ERR    (o_ERR),
      .o_RDATA  (o_RDATA),
      .o_MREQ   (o_MREQ),
      .o_MWE    (o_MWE),
      .o_MADDR  (o_MADDR),
      .o_MWDATA (o_MWDATA),
      .i_MRDATA (i_MRDATA),
      .i_MACK   (i_MACK),
      .o_WADDR  (o_WADDR),
      .o_DATA   (o_DATA),
      .o_WRITE  (o_WRITE)
   );

   task automatic check_output(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Register file: a pointer write seen during a cycle lands just after the
   // following edge. Directed overrides are used to preload a pointer.
   always begin
      logic        w, oe, os;
      logic [3:0]  a;
      logic [15:0] d, ovv;
      @(negedge clk);
      w = o_WRITE; a = o_WADDR; d = o_DATA;
      oe = ov_en; os = ov_sel; ovv = ov_val;
      @(posedge clk);
      #1;
      if (w) begin
         if (a == 4'd1) psp = d;
         else if (a == 4'd2) rsp = d;
      end else if (oe) begin
         if (os) rsp = ovv;
         else psp = ovv;
      end
   end

   // Data memory: acknowledges after ack_delay wait cycles of a held request.
   logic [15:0] mem [0:127];
   initial begin
      int wait_cnt;
      for (int k = 0; k < 128; k++) mem[k] = 16'd0;
      i_MACK = 1'b0;
      i_MRDATA = 16'd0;
      wait_cnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (o_MREQ) begin
            if (wait_cnt == ack_delay) begin
               if (o_MWE) mem[o_MADDR[6:0]] = o_MWDATA;
               i_MRDATA = mem[o_MADDR[6:0]];
               i_MACK = 1'b1;
            end else begin
               i_MACK = 1'b0;
            end
            wait_cnt++;
         end else begin
            i_MACK = 1'b0;
            wait_cnt = 0;
         end
      end
   end

   // Behavioural model: one command is in flight at most. A command either
   // faults (stack depth out of range) for one cycle, or holds a memory
   // request until acknowledged, then reports one write-back cycle.
   logic        e_busy, e_done, e_err, e_mreq, e_mwe, e_write;
   logic [15:0] e_maddr, e_mwdata, e_data, e_rdata;
   logic [3:0]  e_waddr;
   logic        m_op, m_sel;
   logic [15:0] m_sp;

   always @(posedge clk or negedge rst_n) begin
      int depth, cap;
      if (!rst_n) begin
         e_busy = 0; e_done = 0; e_err = 0; e_mreq = 0; e_mwe = 0; e_write = 0;
         e_maddr = 0; e_mwdata = 0; e_data = 0; e_rdata = 0; e_waddr = 0;
         m_op = 0; m_sel = 0; m_sp = 0;
      end else if (!e_busy) begin
         if (i_REQ) begin
            m_op  = i_OP;
            m_sel = i_SEL;
            m_sp  = i_SEL ? i_RSP : i_PSP;
            depth = int'(m_sp) - int'(i_SEL ? RS_BASE : PS_BASE);
            cap   = i_SEL ? int'(RS_LIMIT - RS_BASE) : int'(PS_LIMIT - PS_BASE);
            e_busy = 1;
            if ((!m_op && depth >= cap) || (m_op && depth <= 0)) begin
               e_err = 1;
               e_done = 1;
            end else begin
               e_mreq = 1;
               e_mwe = !m_op;
               e_maddr = m_op ? m_sp - 16'd1 : m_sp;
               e_mwdata = i_WDATA;
            end
         end
      end else if (e_mreq) begin
         if (i_MACK) begin
            e_mreq = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0;
            e_write = 1;
            e_done = 1;
            e_waddr = m_sel ? 4'd2 : 4'd1;
            e_data = m_op ? m_sp - 16'd1 : m_sp + 16'd1;
            if (m_op) e_rdata = i_MRDATA;
         end
      end else begin
         e_busy = 0; e_done = 0; e_err = 0; e_write = 0; e_waddr = 0; e_data = 0;
      end
   end

   // Compare the DUT against the model every cycle, away from the clock edge.
   always @(negedge clk) begin
      check_output("busy", o_BUSY, e_busy);
      check_output("done", o_DONE, e_done);
      check_output("err", o_ERR, e_err);
      check_output("mreq", o_MREQ, e_mreq);
      check_output("write", o_WRITE, e_write);
      check_output("rdata", o_RDATA, e_rdata);
      check_output("exclusive", (int'(o_MREQ) + int'(o_WRITE) + int'(o_ERR)) > 1, 16'd0);
      if (e_mreq) begin
         check_output("mwe", o_MWE, e_mwe);
         check_output("maddr", o_MADDR, e_maddr);
         if (e_mwe) check_output("mwdata", o_MWDATA, e_mwdata);
      end
      if (e_write) begin
         check_output("waddr", o_WADDR, e_waddr);
         check_output("wdata_ptr", o_DATA, e_data);
      end
   end

   // Issue one command; returns 1 time unit after the edge that accepts it.
   task automatic apply_stimulus(input logic op, input logic sel,
                                 input logic [15:0] wd, input int delay);
      @(posedge clk);
      #1;
      ack_delay = delay;
      i_OP = op;
      i_SEL = sel;
      i_WDATA = wd;
      i_REQ = 1'b1;
      @(posedge clk);
      #1;
      i_REQ = 1'b0;
   endtask

   task automatic set_ptr(input logic sel, input logic [15:0] val);
      ov_sel = sel;
      ov_val = val;
      ov_en = 1'b1;
      @(negedge clk);
      #1;
      ov_en = 1'b0;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #100000;
      bad++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, dones;
      rst_n = 1'b0;
      i_REQ = 1'b0; i_OP = 1'b0; i_SEL = 1'b0; i_WDATA = 16'd0;
      repeat (2) @(posedge clk);
      #2;
      check_output("reset_busy", o_BUSY, 1'b0);
      check_output("reset_waddr", o_WADDR, 4'd0);
      check_output("reset_rdata", o_RDATA, 16'd0);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Push BEEF on the parameter stack, acknowledged immediately.
      apply_stimulus(1'b0, 1'b0, 16'hBEEF, 0);
      #1;
      check_output("t1_mreq", o_MREQ, 1'b1);
      check_output("t1_mwe", o_MWE, 1'b1);
      check_output("t1_maddr", o_MADDR, 16'd48);
      check_output("t1_mwdata", o_MWDATA, 16'hBEEF);
      @(posedge clk); #2;
      check_output("t1_write", o_WRITE, 1'b1);
      check_output("t1_waddr", o_WADDR, 4'd1);
      check_output("t1_data", o_DATA, 16'd49);
      check_output("t1_done", o_DONE, 1'b1);
      @(posedge clk); #2;
      check_output("t1_psp", psp, 16'd49);

      // Pop it back with three wait cycles.
      apply_stimulus(1'b1, 1'b0, 16'd0, 3);
      #1;
      check_output("t2_maddr", o_MADDR, 16'd48);
      check_output("t2_mwe", o_MWE, 1'b0);
      n = 0;
      while (o_MREQ && n < 20) begin
         n++;
         @(posedge clk); #2;
      end
      check_output("t2_mreq_cycles", 16'(n), 16'd4);
      check_output("t2_write", o_WRITE, 1'b1);
      check_output("t2_waddr", o_WADDR, 4'd1);
      check_output("t2_data", o_DATA, 16'd48);
      check_output("t2_rdata", o_RDATA, 16'hBEEF);
      @(posedge clk); #2;
      check_output("t2_psp", psp, 16'd48);

      // Overflow on a full parameter stack, underflow on an empty return stack.
      set_ptr(1'b0, 16'd56);
      apply_stimulus(1'b0, 1'b0, 16'h1234, 0);
      #1;
      check_output("t3_err", o_ERR, 1'b1);
      check_output("t3_done", o_DONE, 1'b1);
      check_output("t3_mreq", o_MREQ, 1'b0);
      check_output("t3_write", o_WRITE, 1'b0);
      @(posedge clk); #2;
      check_output("t3_err_clear", o_ERR, 1'b0);
      apply_stimulus(1'b1, 1'b1, 16'd0, 0);
      #1;
      check_output("t3_rs_err", o_ERR, 1'b1);
      check_output("t3_rs_done", o_DONE, 1'b1);
      check_output("t3_rs_mreq", o_MREQ, 1'b0);

      // Last free return-stack slot, then overflow.
      set_ptr(1'b1, 16'd63);
      apply_stimulus(1'b0, 1'b1, 16'hCAFE, 0);
      #1;
      check_output("t4_maddr", o_MADDR, 16'd63);
      @(posedge clk); #2;
      check_output("t4_data", o_DATA, 16'd64);
      check_output("t4_waddr", o_WADDR, 4'd2);
      @(posedge clk); #2;
      check_output("t4_rsp", rsp, 16'd64);
      apply_stimulus(1'b0, 1'b1, 16'h0001, 0);
      #1;
      check_output("t4_err", o_ERR, 1'b1);

      // A second request while busy is dropped.
      set_ptr(1'b0, 16'd50);
      apply_stimulus(1'b0, 1'b0, 16'h5555, 2);
      dones = 0;
      @(posedge clk); #1;
      i_OP = 1'b1; i_SEL = 1'b1; i_REQ = 1'b1;
      @(posedge clk); #1;
      i_REQ = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #2;
         if (o_DONE) dones++;
      end
      check_output("t5_dones", 16'(dones), 16'd1);
      check_output("t5_psp", psp, 16'd51);
      check_output("t5_rsp", rsp, 16'd64);

      // Reset in the middle of a memory request.
      apply_stimulus(1'b0, 1'b0, 16'hAAAA, 30);
      #1;
      check_output("t6_mreq_before", o_MREQ, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_output("t6_mreq", o_MREQ, 1'b0);
      check_output("t6_busy", o_BUSY, 1'b0);
      check_output("t6_write", o_WRITE, 1'b0);
      check_output("t6_rdata", o_RDATA, 16'd0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #2;
      check_output("t6_psp_kept", psp, 16'd51);
      apply_stimulus(1'b0, 1'b0, 16'h7777, 0);
      #1;
      check_output("t6_maddr", o_MADDR, 16'd51);
      @(posedge clk); #2;
      check_output("t6_data", o_DATA, 16'd52);
      check_output("t6_done", o_DONE, 1'b1);
      @(posedge clk); #2;
      check_output("t6_psp", psp, 16'd52);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stack_port.md
Name: stack_port

Overview:
- Sequencer that runs one Forth stack push or pop per command against data memory.
- Reads the current stack pointer (PSP or RSP) as exported by the register file.
- Runs a request/acknowledge memory transaction.
- Writes the updated pointer back through the register-file write port: o_WADDR/o_DATA/o_WRITE map onto i_WADDR/i_DATA/f_WRITE.
- Sits between the control unit and the register file/memory arbiter; it consumes pointers and produces pointer writes, the reverse direction of the register file.

Parameters:
- PS_BASE, 48: lowest parameter-stack address; PSP value when the stack is empty.
- PS_LIMIT, 56: PSP value when the parameter stack is full.
- RS_BASE, 56: lowest return-stack address; RSP value when the stack is empty.
- RS_LIMIT, 64: RSP value when the return stack is full.

Ports:
- c_CLOCK  in  1  single system clock; all state changes on posedge.
- c_RESET_N  in  1  asynchronous, active-low reset.
- i_REQ  in  1  command request, sampled in IDLE only.
- i_OP  in  1  0 = push, 1 = pop.
- i_SEL  in  1  0 = parameter stack (PSP, reg 1), 1 = return stack (RSP, reg 2).
- i_WDATA  in  16  push data.
- i_PSP  in  16  current PSP from the register file.
- i_RSP  in  16  current RSP from the register file.
- o_BUSY  out  1  high in every state except IDLE.
- o_DONE  out  1  one-cycle completion pulse.
- o_ERR  out  1  one-cycle overflow/underflow pulse, coincident with o_DONE.
- o_RDATA  out  16  popped data, held until the next successful pop.
- o_MREQ  out  1  memory request.
- o_MWE  out  1  1 = memory write.
- o_MADDR  out  16  memory address.
- o_MWDATA  out  16  memory write data.
- i_MRDATA  in  16  memory read data, valid when i_MACK is high.
- i_MACK  in  1  memory acknowledge.
- o_WADDR  out  4  register-file write address (1 or 2).
- o_DATA  out  16  new pointer value.
- o_WRITE  out  1  register-file write strobe.

Behaviour:
- Reset (async, c_RESET_N=0): state IDLE. All outputs 0, including o_RDATA and o_WADDR. An in-flight memory request is dropped immediately with no pointer write. After reset release, the block waits for i_REQ.
- States: IDLE, MEM, WB, ERR. Encoding is free.
- IDLE, i_REQ=1 at posedge:
  - Latch op, sel, i_WDATA, and SP (i_PSP if sel=0, else i_RSP).
  - Select base/limit from sel.
  - Push with SP >= limit, or pop with SP <= base: go to ERR.
  - Otherwise go to MEM.
  - i_REQ=0: stay in IDLE.
- MEM: o_MREQ=1.
  - Push: o_MWE=1, o_MADDR=SP, o_MWDATA=latched data.
  - Pop: o_MWE=0, o_MADDR=SP-1.
  - Request outputs hold stable until i_MACK=1 is sampled; there is no timeout.
  - On the ack edge: for a pop, o_RDATA <= i_MRDATA; go to WB.
  - o_MREQ drops in WB.
- WB (exactly one cycle):
  - o_WRITE=1, o_WADDR = 1 (sel=0) or 2 (sel=1).
  - o_DATA = SP+1 (push) or SP-1 (pop), mod 2^16.
  - o_DONE=1. Next state IDLE.
- ERR (exactly one cycle): o_ERR=1, o_DONE=1, no o_MREQ, no o_WRITE. Next state IDLE.
- Latency with i_MACK in the first MEM cycle: accept edge, then MEM for 1 cycle, then WB for 1 cycle, so o_DONE is high 2 cycles after accept. Each extra wait cycle adds one cycle.
- Throughput: a new command is accepted no earlier than the first IDLE cycle after WB/ERR, so at most one command per 3 cycles.
- i_REQ while o_BUSY=1 is ignored, not queued. The requester holds or reissues after o_DONE.
- i_PSP/i_RSP changes after accept have no effect, because SP is latched.
- o_MREQ, o_WRITE and o_ERR are never high in the same cycle.
- i_MACK outside MEM is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset PSP=48, push i_WDATA=16'hBEEF on PS, MACK in first MEM cycle -> MREQ=1, MWE=1, MADDR=48, MWDATA=BEEF. Then WB: WRITE=1, WADDR=1, DATA=49, DONE=1, two cycles after accept.
- PSP=49, pop PS, MACK after 3 wait cycles with MRDATA=16'hBEEF -> MADDR=48, MWE=0, MREQ held 4 cycles. Then RDATA=BEEF, WRITE with WADDR=1, DATA=48.
- PSP=56, push PS -> ERR cycle: ERR=1, DONE=1, no MREQ, no WRITE. Same for RSP=56 with pop on RS (underflow).
- RSP=63, push RS -> MADDR=63, DATA=64. A following push with RSP=64 -> ERR.
- Pulse i_REQ with a second command while BUSY -> second command ignored. Exactly one DONE; pointer changes once.
- Assert c_RESET_N=0 mid-MEM (MREQ=1) -> MREQ, BUSY, WRITE drop to 0 immediately, no WB. After release, a push completes normally.
